// File: rtl/uart_line_buffer.sv
// Line-mode buffer between UART RX and UART TX: collects a line with backspace
// editing and, on CR, replays the stored line followed by CR (and optionally LF).
module uart_line_buffer #(
  parameter int   DEPTH     = 64,
  parameter bit   APPEND_LF = 1'b1,
  localparam int  LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [LEN_W-1:0] line_len,
  output logic             overflow,
  output logic             busy
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_DEL = 8'h7F;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SEND    = 2'd1,
    ST_SEND_CR = 2'd2,
    ST_SEND_LF = 2'd3
  } state_t;

  // Handshake rule on both sides: a byte moves on a clk edge where valid and
  // ready are both 1; once m_axis_tvalid is raised, it and m_axis_tdata hold
  // until that edge.
  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_nxt;
  logic [IDX_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] w_rd_ptr_nxt;
  logic             r_s_ready;
  logic             w_s_ready_nxt;
  logic             r_m_valid;
  logic             w_m_valid_nxt;
  logic [7:0]       r_m_data;
  logic [7:0]       w_m_data_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             w_wr_en;
  logic [7:0]       r_mem [DEPTH];

  logic             w_s_hs;
  logic             w_m_hs;
  logic             w_last;
  logic [IDX_W-1:0] w_rd_inc;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_s_hs   = s_axis_tvalid & r_s_ready;
  assign w_m_hs   = r_m_valid & m_axis_tready;
  assign w_rd_inc = r_rd_ptr + IDX_W'(1);
  assign w_wr_idx = r_count[IDX_W-1:0];
  assign w_last   = (LEN_W'(r_rd_ptr) == (r_count - LEN_W'(1)));

  // Line storage: no reset needed, only count decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_COLLECT;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_m_data  <= w_m_data_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_s_ready_nxt = r_s_ready;
    w_m_valid_nxt = r_m_valid;
    w_m_data_nxt  = r_m_data;
    w_ovf_nxt     = 1'b0;
    w_wr_en       = 1'b0;

    case (r_state)
      ST_COLLECT: begin
        w_s_ready_nxt = 1'b1;
        w_m_valid_nxt = 1'b0;
        if (w_s_hs) begin
          case (s_axis_tdata)
            CH_CR: begin
              w_s_ready_nxt = 1'b0;
              w_m_valid_nxt = 1'b1;
              w_rd_ptr_nxt  = '0;
              if (r_count != '0) begin
                w_state_nxt  = ST_SEND;
                w_m_data_nxt = r_mem[0];
              end else begin
                w_state_nxt  = ST_SEND_CR;
                w_m_data_nxt = CH_CR;
              end
            end
            CH_BS, CH_DEL: begin
              if (r_count != '0) begin
                w_count_nxt = r_count - LEN_W'(1);
              end
            end
            CH_LF: begin
              w_count_nxt = r_count;
            end
            default: begin
              // Full buffer: the byte is dropped and flagged, count stays saturated.
              if (r_count < LEN_W'(DEPTH)) begin
                w_wr_en     = 1'b1;
                w_count_nxt = r_count + LEN_W'(1);
              end else begin
                w_ovf_nxt = 1'b1;
              end
            end
          endcase
        end
      end

      ST_SEND: begin
        if (w_m_hs) begin
          if (w_last) begin
            w_state_nxt  = ST_SEND_CR;
            w_m_data_nxt = CH_CR;
          end else begin
            w_rd_ptr_nxt = w_rd_inc;
            w_m_data_nxt = r_mem[w_rd_inc];
          end
        end
      end

      ST_SEND_CR: begin
        if (w_m_hs) begin
          if (APPEND_LF) begin
            w_state_nxt  = ST_SEND_LF;
            w_m_data_nxt = CH_LF;
          end else begin
            w_state_nxt   = ST_COLLECT;
            w_m_valid_nxt = 1'b0;
            w_s_ready_nxt = 1'b1;
            w_count_nxt   = '0;
            w_rd_ptr_nxt  = '0;
          end
        end
      end

      ST_SEND_LF: begin
        if (w_m_hs) begin
          w_state_nxt   = ST_COLLECT;
          w_m_valid_nxt = 1'b0;
          w_s_ready_nxt = 1'b1;
          w_count_nxt   = '0;
          w_rd_ptr_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = ST_COLLECT;
      end
    endcase
  end

  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign line_len      = r_count;
  assign overflow      = r_ovf;
  assign busy          = (r_state != ST_COLLECT);

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: three instances (default, DEPTH=4, no LF) driven
// from a table of line vectors plus hand-written reset and backspace sequences.
module tb_uart_line_buffer;

  typedef struct {
    int    inst;
    string din;
    string dout;
    int    n_ovf;
    bit    stall;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] s_valid = '0;
  logic [7:0] s_data = '0;
  logic       m_ready = 1'b1;
  logic [2:0] s_ready;
  logic [2:0] m_valid;
  logic [2:0] ovf;
  logic [2:0] busy;
  logic [7:0] m_data_a [3];
  logic [6:0] len_main;
  logic [2:0] len_d4;
  logic [6:0] len_nolf;

  uart_line_buffer #(.DEPTH(64), .APPEND_LF(1'b1)) u_main (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]),
    .m_axis_tdata(m_data_a[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready),
    .line_len(len_main), .overflow(ovf[0]), .busy(busy[0])
  );

  uart_line_buffer #(.DEPTH(4), .APPEND_LF(1'b1)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]),
    .m_axis_tdata(m_data_a[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready),
    .line_len(len_d4), .overflow(ovf[1]), .busy(busy[1])
  );

  uart_line_buffer #(.DEPTH(64), .APPEND_LF(1'b0)) u_nolf (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid[2]), .s_axis_tready(s_ready[2]),
    .m_axis_tdata(m_data_a[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready),
    .line_len(len_nolf), .overflow(ovf[2]), .busy(busy[2])
  );

  int checks = 0;
  int failures = 0;
  int cur = 0;
  int rdy_mode = 0;

  // monitor state, written only by the monitor process
  logic [7:0] got_q [$];
  int         got_cyc [$];
  int         cyc = 0;
  int         ovf_cnt = 0;
  int         busy_cnt = 0;
  int         stall_err = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  // scoreboard expectations
  logic [7:0] exp_q [$];

  function automatic int len_of(input int i);
    case (i)
      0: return int'(len_main);
      1: return int'(len_d4);
      default: return int'(len_nolf);
    endcase
  endfunction

  function automatic vec_t mk(input int inst, input string din, input string dout,
                              input int n_ovf, input bit stall);
    vec_t v;
    v.inst = inst;
    v.din = din;
    v.dout = dout;
    v.n_ovf = n_ovf;
    v.stall = stall;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // TX ready pattern: 0 always ready, 1 random, other never ready
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(m_valid[cur] && (m_data_a[cur] == prev_data))) stall_err++;
      if (m_valid[cur] && m_ready) begin
        got_q.push_back(m_data_a[cur]);
        got_cyc.push_back(cyc);
      end
      prev_stall = m_valid[cur] && !m_ready;
      prev_data = m_data_a[cur];
      if (ovf[cur]) ovf_cnt++;
      if (busy[cur]) busy_cnt++;
    end
  end

  // driver: called at posedge+1, returns at posedge+1 after the accepting edge
  task automatic send_byte(input int inst, input logic [7:0] b);
    bit done;
    done = 1'b0;
    s_data = b;
    s_valid = '0;
    s_valid[inst] = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (s_ready[inst]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int base, ovf0, busy0, st0, n_out, n_term;
    bit done;
    base = got_q.size();
    ovf0 = ovf_cnt;
    busy0 = busy_cnt;
    st0 = stall_err;
    n_out = v.dout.len();
    n_term = (v.inst == 2) ? 1 : 2;
    exp_q.delete();
    for (int k = 0; k < n_out; k++) exp_q.push_back(v.dout[k]);
    cur = v.inst;
    rdy_mode = v.stall ? 1 : 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < v.din.len(); k++) begin
      if (k == v.din.len() - 1)
        chk($sformatf("v%0d_len_before_cr", id), len_of(v.inst), n_out - n_term);
      send_byte(v.inst, v.din[k]);
    end
    s_valid = '0;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge clk);
      #1;
      if (got_q.size() >= base + n_out && !busy[cur] && s_ready[cur]) done = 1'b1;
    end
    chk($sformatf("v%0d_done", id), int'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d_out_count", id), got_q.size() - base, n_out);
    for (int k = 0; k < n_out; k++) begin
      if (base + k < got_q.size())
        chk($sformatf("v%0d_byte%0d", id, k), int'(got_q[base + k]), int'(exp_q[k]));
    end
    chk($sformatf("v%0d_overflow_cycles", id), ovf_cnt - ovf0, v.n_ovf);
    chk($sformatf("v%0d_stall_stable", id), stall_err - st0, 0);
    if (!v.stall && got_q.size() >= base + n_out) begin
      chk($sformatf("v%0d_back_to_back", id), got_cyc[base + n_out - 1] - got_cyc[base], n_out - 1);
      chk($sformatf("v%0d_busy_cycles", id), busy_cnt - busy0, n_out);
    end
    chk($sformatf("v%0d_len_after", id), len_of(v.inst), 0);
    chk($sformatf("v%0d_ready_after", id), int'(s_ready[v.inst]), 1);
    chk($sformatf("v%0d_valid_after", id), int'(m_valid[v.inst]), 0);
  endtask

  vec_t vecs [9];

  initial begin
    int base;
    vecs[0] = mk(0, "AB\015",          "AB\015\012",   0, 1'b0);
    vecs[1] = mk(0, "\010AX\010B\015", "AB\015\012",   0, 1'b0);
    vecs[2] = mk(1, "ABCDEF\015",      "ABCD\015\012", 2, 1'b0);
    vecs[3] = mk(0, "HELLO\015",       "HELLO\015\012", 0, 1'b1);
    vecs[4] = mk(0, "\012\015",        "\015\012",     0, 1'b0);
    vecs[5] = mk(2, "Z\015",           "Z\015",        0, 1'b0);
    vecs[6] = mk(0, "\177a\177\015",   "\015\012",     0, 1'b0);
    vecs[7] = mk(1, "WXYZ\010Q\015",   "WXYQ\015\012", 0, 1'b0);
    vecs[8] = mk(2, "Hi\015",          "Hi\015",       0, 1'b0);

    // reset values
    #23;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_s_ready%0d", i), int'(s_ready[i]), 0);
      chk($sformatf("rst_m_valid%0d", i), int'(m_valid[i]), 0);
      chk($sformatf("rst_m_data%0d", i), int'(m_data_a[i]), 0);
      chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
      chk($sformatf("rst_overflow%0d", i), int'(ovf[i]), 0);
      chk($sformatf("rst_len%0d", i), len_of(i), 0);
    end
    #9 rst_n = 1'b1;
    #1 chk("ready_before_edge", int'(s_ready[0]), 0);
    @(posedge clk);
    #1 chk("ready_after_edge", int'(s_ready[0]), 1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // backspace on an empty buffer never underflows
    cur = 0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send_byte(0, 8'h08);
    chk("bs_empty_len", len_of(0), 0);
    send_byte(0, 8'h41);
    chk("bs_one_len", len_of(0), 1);
    send_byte(0, 8'h08);
    chk("bs_back_len", len_of(0), 0);
    send_byte(0, 8'h7F);
    chk("del_empty_len", len_of(0), 0);
    s_valid = '0;

    // reset in the middle of sending "ABCD"
    base = got_q.size();
    @(posedge clk);
    #1;
    send_byte(0, 8'h41);
    send_byte(0, 8'h42);
    send_byte(0, 8'h43);
    send_byte(0, 8'h44);
    send_byte(0, 8'h0D);
    s_valid = '0;
    for (int t = 0; t < 50 && got_q.size() < base + 2; t++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(m_valid[0]), 0);
    chk("midrst_ready", int'(s_ready[0]), 0);
    chk("midrst_busy", int'(busy[0]), 0);
    chk("midrst_len", len_of(0), 0);
    chk("midrst_sent", got_q.size() - base, 2);
    if (got_q.size() >= base + 2) begin
      chk("midrst_byte0", int'(got_q[base]), 8'h41);
      chk("midrst_byte1", int'(got_q[base + 1]), 8'h42);
    end
    #20 rst_n = 1'b1;
    #1 chk("rel_ready_before_edge", int'(s_ready[0]), 0);
    @(posedge clk);
    #1;
    chk("rel_ready", int'(s_ready[0]), 1);
    chk("rel_len", len_of(0), 0);
    chk("rel_valid", int'(m_valid[0]), 0);
    run_vec(mk(0, "Q\015", "Q\015\012", 0, 1'b0), 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
